// File: rtl/vga_pkg.sv
// Shared timing constants, arbiter state encoding and row address type for the
// video row-memory fetch path.
`timescale 1ns/1ps
package vga_pkg;

    localparam int unsigned VACTIVE       = 480;
    localparam int unsigned VLINES        = 525;
    localparam int unsigned LINES_PER_ROW = 20;
    localparam int unsigned ROWS          = 24;
    localparam int unsigned ADDR_W        = 5;
    localparam int unsigned DATA_W        = 64;

    typedef logic [ADDR_W-1:0] row_addr_t;

    typedef enum logic [1:0] {
        StIdle,
        StCpuWr,
        StFetchRd,
        StFetchWait
    } arb_state_t;

endpackage

// File: rtl/vga_row_tracker.sv
// Follows line_start/vline with phase and row counters and flags the line that must
// prefetch the next bitmap row and the line on which that row goes on screen.
`timescale 1ns/1ps
module vga_row_tracker #(
    parameter int unsigned ROWS          = vga_pkg::ROWS,
    parameter int unsigned ADDR_W        = vga_pkg::ADDR_W,
    parameter int unsigned LINES_PER_ROW = vga_pkg::LINES_PER_ROW,
    parameter int unsigned VACTIVE       = vga_pkg::VACTIVE,
    parameter int unsigned VLINES        = vga_pkg::VLINES
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              line_start,
    input  logic [9:0]        vline,
    output logic              fetch_trigger,
    output logic              swap_now,
    output logic [ADDR_W-1:0] fetch_row
);
    import vga_pkg::*;

    localparam int unsigned PHASE_W = $clog2(LINES_PER_ROW);
    // Rows actually shown, never more than the memory holds.
    localparam int unsigned LAST_ROW =
        (VACTIVE / LINES_PER_ROW < ROWS) ? VACTIVE / LINES_PER_ROW : ROWS;

    // phase/row describe N = vline + 1 of the next line_start: N % LINES_PER_ROW and
    // N / LINES_PER_ROW. Reset value matches the line_start with vline = VLINES-1.
    logic [PHASE_W-1:0] phase;
    logic [ADDR_W-1:0]  row;
    logic               wrap;
    logic               row_active;

    always_comb begin
        wrap          = line_start && (vline == 10'(VLINES - 1));
        row_active    = (row < ADDR_W'(LAST_ROW));
        fetch_trigger = line_start && (wrap || ((phase == '0) && row_active));
        fetch_row     = wrap ? '0 : row;
        // Phase 1 means the previous line_start had N % LINES_PER_ROW == 0, i.e. this
        // line's vline sits on a band boundary.
        swap_now      = line_start && !wrap && (phase == PHASE_W'(1)) && row_active;
    end

    always_ff @(posedge dclk) begin
        if (clr) begin
            phase <= '0;
            row   <= '0;
        end else if (line_start) begin
            if (wrap) begin
                phase <= PHASE_W'(1);
                row   <= '0;
            end else if (phase == PHASE_W'(LINES_PER_ROW - 1)) begin
                phase <= '0;
                if (row_active) begin
                    row <= row + ADDR_W'(1);
                end
            end else begin
                phase <= phase + PHASE_W'(1);
            end
        end
    end

endmodule

// File: rtl/vga_fetch_arbiter.sv
// Arbitrates the single-port row memory between display prefetch (priority) and CPU
// writes, and double-buffers the fetched row word into vdata at each band boundary.
`timescale 1ns/1ps
module vga_fetch_arbiter #(
    parameter int unsigned ROWS          = vga_pkg::ROWS,
    parameter int unsigned ADDR_W        = vga_pkg::ADDR_W,
    parameter int unsigned DATA_W        = vga_pkg::DATA_W,
    parameter int unsigned LINES_PER_ROW = vga_pkg::LINES_PER_ROW,
    parameter int unsigned VACTIVE       = vga_pkg::VACTIVE,
    parameter int unsigned VLINES        = vga_pkg::VLINES
) (
    input  logic              dclk,
    input  logic              clr,
    input  logic              line_start,
    input  logic [9:0]        vline,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] vdata,
    input  logic              miss_clr,
    output logic              fetch_miss
);
    import vga_pkg::*;

    logic              fetch_trigger;
    logic              swap_now;
    logic [ADDR_W-1:0] trig_row;

    arb_state_t        state;
    logic [ADDR_W-1:0] frow;
    logic [DATA_W-1:0] stage;
    logic              pending;

    vga_row_tracker #(
        .ROWS          (ROWS),
        .ADDR_W        (ADDR_W),
        .LINES_PER_ROW (LINES_PER_ROW),
        .VACTIVE       (VACTIVE),
        .VLINES        (VLINES)
    ) u_row_tracker (
        .dclk          (dclk),
        .clr           (clr),
        .line_start    (line_start),
        .vline         (vline),
        .fetch_trigger (fetch_trigger),
        .swap_now      (swap_now),
        .fetch_row     (trig_row)
    );

    always_ff @(posedge dclk) begin
        if (clr) begin
            state      <= StIdle;
            frow       <= '0;
            stage      <= '0;
            pending    <= 1'b0;
            vdata      <= '0;
            fetch_miss <= 1'b0;
            cpu_ack    <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            cpu_ack <= 1'b0;
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;

            // A later trigger simply retargets the outstanding fetch.
            if (fetch_trigger) begin
                frow <= trig_row;
            end

            case (state)
                StIdle: begin
                    if (pending) begin
                        state    <= StFetchRd;
                        mem_en   <= 1'b1;
                        mem_addr <= frow;
                    end else if (cpu_req) begin
                        state     <= StCpuWr;
                        mem_en    <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= cpu_addr;
                        mem_wdata <= cpu_wdata;
                        cpu_ack   <= 1'b1;
                    end
                end
                StCpuWr: begin
                    state <= StIdle;
                end
                StFetchRd: begin
                    state <= StFetchWait;
                end
                StFetchWait: begin
                    stage <= mem_rdata;
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase

            if (fetch_trigger) begin
                pending <= 1'b1;
            end else if (swap_now || (state == StFetchWait)) begin
                pending <= 1'b0;
            end

            // A fetch still outstanding at its swap line keeps the old word on screen.
            if (swap_now && !pending) begin
                vdata <= stage;
            end

            if (swap_now && pending) begin
                fetch_miss <= 1'b1;
            end else if (miss_clr) begin
                fetch_miss <= 1'b0;
            end
        end
    end

endmodule
